// File: rtl/esfa_bench_sequencer.sv
// Benchmark sequencer for ESFATop: issues back-to-back doRun handshakes,
// enforces start/run timeouts and accumulates result and cycle statistics.
module esfa_bench_sequencer #(
    parameter int CNT_W         = 16,
    parameter int CYC_W         = 32,
    parameter int START_TIMEOUT = 64,
    parameter int RUN_TIMEOUT   = 1000000,
    parameter int GAP_CYCLES    = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_num_runs,
    output logic             o_do_run,
    input  logic             i_dut_is_running,
    input  logic             i_dut_was_successful,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_aborted,
    output logic [CNT_W-1:0] o_pass_count,
    output logic [CNT_W-1:0] o_fail_count,
    output logic [CNT_W-1:0] o_timeout_count,
    output logic [CYC_W-1:0] o_last_cycles,
    output logic [CYC_W-1:0] o_max_cycles,
    output logic [CYC_W-1:0] o_total_cycles
);

    localparam int TMO_MAX =
        (RUN_TIMEOUT > START_TIMEOUT) ? RUN_TIMEOUT : START_TIMEOUT;
    localparam int TMO_W = $clog2(TMO_MAX + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1) + 1;

    localparam logic [TMO_W-1:0] START_LIM = TMO_W'(START_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] RUN_LIM   = TMO_W'(RUN_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
    localparam logic [GAP_W-1:0] GAP_LIM   =
        (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_START,
        S_WAIT_DONE,
        S_RECORD,
        S_GAP,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_do_run;
    logic             r_busy;
    logic             r_done;
    logic             r_aborted;
    logic [CNT_W-1:0] r_pass;
    logic [CNT_W-1:0] r_fail;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic [CYC_W-1:0] r_last;
    logic [CYC_W-1:0] r_max;
    logic [CYC_W-1:0] r_total;
    logic [CNT_W-1:0] r_remaining;
    logic [CYC_W-1:0] r_cyc;
    logic [TMO_W-1:0] r_tmo;
    logic [GAP_W-1:0] r_gap;
    logic             r_tmo_hit;
    logic             r_success;

    logic [CYC_W:0]   w_total_sum;
    logic [CYC_W-1:0] w_cyc_inc;
    logic             w_abortable;
    logic             w_gap_met;

    function automatic logic [CNT_W-1:0] f_sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    assign w_total_sum = {1'b0, r_total} + {1'b0, r_cyc};
    assign w_cyc_inc   = (r_cyc == '1) ? r_cyc : r_cyc + CYC_ONE;
    assign w_gap_met   = (r_gap >= GAP_LIM) && !i_dut_is_running;

    // GAP handles its own abort so a held abort cannot restart the gap count
    assign w_abortable = i_abort &&
                         (r_state == S_LAUNCH ||
                          r_state == S_WAIT_START ||
                          r_state == S_WAIT_DONE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_do_run    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_pass      <= '0;
            r_fail      <= '0;
            r_tmo_cnt   <= '0;
            r_last      <= '0;
            r_max       <= '0;
            r_total     <= '0;
            r_remaining <= '0;
            r_cyc       <= '0;
            r_tmo       <= '0;
            r_gap       <= '0;
            r_tmo_hit   <= 1'b0;
            r_success   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abortable) begin
                r_state     <= S_GAP;
                r_do_run    <= 1'b0;
                r_aborted   <= 1'b1;
                r_remaining <= '0;
                r_gap       <= '0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_remaining <= i_num_runs;
                            r_pass      <= '0;
                            r_fail      <= '0;
                            r_tmo_cnt   <= '0;
                            r_last      <= '0;
                            r_max       <= '0;
                            r_total     <= '0;
                            r_aborted   <= 1'b0;
                            r_busy      <= 1'b1;
                            if (i_num_runs == '0) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state  <= S_LAUNCH;
                                r_do_run <= 1'b1;
                            end
                        end
                    end
                    S_LAUNCH: begin
                        r_cyc     <= CYC_ONE;
                        r_tmo     <= '0;
                        r_tmo_hit <= 1'b0;
                        r_success <= 1'b0;
                        r_state   <= S_WAIT_START;
                    end
                    S_WAIT_START: begin
                        r_cyc <= w_cyc_inc;
                        if (i_dut_is_running) begin
                            r_state <= S_WAIT_DONE;
                            r_tmo   <= '0;
                        end else if (r_tmo == START_LIM) begin
                            r_tmo_hit <= 1'b1;
                            r_do_run  <= 1'b0;
                            r_state   <= S_RECORD;
                        end else begin
                            r_tmo <= r_tmo + TMO_ONE;
                        end
                    end
                    S_WAIT_DONE: begin
                        r_cyc <= w_cyc_inc;
                        if (!i_dut_is_running) begin
                            r_success <= i_dut_was_successful;
                            r_do_run  <= 1'b0;
                            r_state   <= S_RECORD;
                        end else if (r_tmo == RUN_LIM) begin
                            r_tmo_hit <= 1'b1;
                            r_do_run  <= 1'b0;
                            r_state   <= S_RECORD;
                        end else begin
                            r_tmo <= r_tmo + TMO_ONE;
                        end
                    end
                    S_RECORD: begin
                        r_last <= r_cyc;
                        if (r_cyc > r_max) begin
                            r_max <= r_cyc;
                        end
                        r_total <= w_total_sum[CYC_W] ?
                                   '1 : w_total_sum[CYC_W-1:0];
                        if (r_tmo_hit) begin
                            r_tmo_cnt <= f_sat_inc(r_tmo_cnt);
                        end else if (r_success) begin
                            r_pass <= f_sat_inc(r_pass);
                        end else begin
                            r_fail <= f_sat_inc(r_fail);
                        end
                        if (r_remaining != '0) begin
                            r_remaining <= r_remaining - CNT_ONE;
                        end
                        r_gap   <= '0;
                        r_state <= S_GAP;
                    end
                    S_GAP: begin
                        if (i_abort) begin
                            r_aborted   <= 1'b1;
                            r_remaining <= '0;
                        end
                        if (w_gap_met) begin
                            if (!i_abort && r_remaining != '0) begin
                                r_state  <= S_LAUNCH;
                                r_do_run <= 1'b1;
                            end else begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end else if (r_gap < GAP_LIM) begin
                            r_gap <= r_gap + GAP_ONE;
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_do_run <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_do_run        = r_do_run;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_aborted       = r_aborted;
    assign o_pass_count    = r_pass;
    assign o_fail_count    = r_fail;
    assign o_timeout_count = r_tmo_cnt;
    assign o_last_cycles   = r_last;
    assign o_max_cycles    = r_max;
    assign o_total_cycles  = r_total;

endmodule

// File: tb/tb_esfa_bench_sequencer.sv
// Bench for esfa_bench_sequencer: behavioural core model plus
// arithmetic reference for per-run cycle counts and result totals.
module tb_esfa_bench_sequencer;

    localparam int CNT_W = 16;
    localparam int CYC_W = 32;
    localparam int ST    = 64;
    localparam int RT    = 100;
    localparam int GAP   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_runs;
    logic             is_run;
    logic             was_succ;
    logic             do_run;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] pass_c;
    logic [CNT_W-1:0] fail_c;
    logic [CNT_W-1:0] tmo_c;
    logic [CYC_W-1:0] last_c;
    logic [CYC_W-1:0] max_c;
    logic [CYC_W-1:0] total_c;

    int errors = 0;
    int checks = 0;

    // per-run core behaviour: rise delay, high time, success bit
    int run_d[$];
    int run_h[$];
    bit run_s[$];

    int cur;
    int k;
    int dr_len;
    int low_len;
    int pend_val;
    bit prev_do_run;
    bit pend_last;
    bit abort_hit;

    always #5 clk = ~clk;

    esfa_bench_sequencer #(
        .CNT_W(CNT_W),
        .CYC_W(CYC_W),
        .START_TIMEOUT(ST),
        .RUN_TIMEOUT(RT),
        .GAP_CYCLES(GAP)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_start(start),
        .i_abort(abort),
        .i_num_runs(num_runs),
        .o_do_run(do_run),
        .i_dut_is_running(is_run),
        .i_dut_was_successful(was_succ),
        .o_busy(busy),
        .o_done(done),
        .o_aborted(aborted),
        .o_pass_count(pass_c),
        .o_fail_count(fail_c),
        .o_timeout_count(tmo_c),
        .o_last_cycles(last_c),
        .o_max_cycles(max_c),
        .o_total_cycles(total_c)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // do_run-high cycles: launch + start wait + done wait, each capped
    function automatic int exp_cyc(input int d, input int h);
        if (d > ST) return ST + 1;
        if (h > RT) return 1 + d + RT;
        return 1 + d + h;
    endfunction

    function automatic bit is_tmo(input int d, input int h);
        return (d > ST) || (h > RT);
    endfunction

    task automatic add_run(input int d, input int h, input bit s);
        run_d.push_back(d);
        run_h.push_back(h);
        run_s.push_back(s);
    endtask

    task automatic clear_runs();
        run_d.delete();
        run_h.delete();
        run_s.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pend_last) begin
            chk("last_cycles", last_c, pend_val);
            pend_last = 0;
        end
        if (do_run && !prev_do_run) begin
            chk("gap_low_cycles", low_len >= GAP, 1);
            chk("launch_irun_low", is_run, 0);
            cur++;
            k = 0;
            dr_len = 0;
        end else if (cur >= 0) begin
            k++;
        end
        if (!do_run && prev_do_run && !abort_hit &&
            cur >= 0 && cur < run_d.size()) begin
            pend_val = exp_cyc(run_d[cur], run_h[cur]);
            chk("run_len", dr_len, pend_val);
            pend_last = 1;
        end
        if (do_run) begin
            dr_len++;
            low_len = 0;
        end else begin
            low_len++;
        end
        prev_do_run = do_run;
        if (cur >= 0 && cur < run_d.size()) begin
            is_run = (k >= run_d[cur]) && (k < run_d[cur] + run_h[cur]);
            was_succ = run_s[cur];
        end else begin
            is_run = 0;
            was_succ = 0;
        end
    endtask

    task automatic run_seq(input int n, input int abort_run,
                           input int ghost_run, input string tag);
        int nrec;
        int c;
        int e_pass = 0;
        int e_fail = 0;
        int e_tmo = 0;
        int e_max = 0;
        int e_last = 0;
        longint e_tot = 0;
        bit got_done = 0;
        bit ab_pending = 0;
        int done_step = -1;
        cur = -1;
        k = 0;
        abort_hit = 0;
        pend_last = 0;
        start = 1;
        abort = 0;
        num_runs = CNT_W'(n);
        for (int i = 0; i < 6000 && !got_done; i++) begin
            step();
            start = 0;
            abort = 0;
            if (i == 0) num_runs = CNT_W'($urandom);
            if (ab_pending) begin
                chk({tag, "_abort_do_run"}, do_run, 0);
                chk({tag, "_abort_flag"}, aborted, 1);
                ab_pending = 0;
            end
            if (done) begin
                got_done = 1;
                done_step = i;
            end else if (cur >= 0) begin
                if (cur == abort_run && !abort_hit &&
                    k == run_d[cur] + 2) begin
                    abort = 1;
                    abort_hit = 1;
                    ab_pending = 1;
                end
                if (cur == ghost_run && k == 3) begin
                    start = 1;
                    num_runs = CNT_W'(7);
                end
            end
        end
        chk({tag, "_done_seen"}, got_done, 1);
        if (got_done) begin
            nrec = (abort_run >= 0) ? abort_run : n;
            for (int r = 0; r < nrec; r++) begin
                c = exp_cyc(run_d[r], run_h[r]);
                if (is_tmo(run_d[r], run_h[r])) e_tmo++;
                else if (run_s[r]) e_pass++;
                else e_fail++;
                e_tot += c;
                if (c > e_max) e_max = c;
                e_last = c;
            end
            chk({tag, "_launched"}, cur + 1,
                (abort_run >= 0) ? abort_run + 1 : n);
            chk({tag, "_pass"}, pass_c, e_pass);
            chk({tag, "_fail"}, fail_c, e_fail);
            chk({tag, "_timeout"}, tmo_c, e_tmo);
            chk({tag, "_last"}, last_c, e_last);
            chk({tag, "_max"}, max_c, e_max);
            chk({tag, "_total"}, total_c, e_tot);
            chk({tag, "_aborted"}, aborted, abort_run >= 0);
            chk({tag, "_busy_at_done"}, busy, 1);
            if (abort_run < 0) begin
                chk({tag, "_sum_runs"}, pass_c + fail_c + tmo_c, n);
            end
            if (n == 0) chk({tag, "_done_latency"}, done_step, 0);
            step();
            chk({tag, "_done_pulse"}, done, 0);
            chk({tag, "_busy_after"}, busy, 0);
        end
    endtask

    initial begin
        reset = 1;
        start = 0;
        abort = 0;
        num_runs = '0;
        is_run = 0;
        was_succ = 0;
        cur = -1;
        k = 0;
        prev_do_run = 0;
        pend_last = 0;
        abort_hit = 0;
        low_len = 100;
        repeat (3) step();
        chk("rst_do_run", do_run, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_pass", pass_c, 0);
        chk("rst_fail", fail_c, 0);
        chk("rst_tmo", tmo_c, 0);
        chk("rst_last", last_c, 0);
        chk("rst_max", max_c, 0);
        chk("rst_total", total_c, 0);
        reset = 0;
        repeat (2) step();

        clear_runs();
        add_run(2, 8, 1);
        run_seq(1, -1, -1, "single");

        clear_runs();
        add_run(2, 8, 1);
        add_run(2, 20, 0);
        add_run(2, 5, 1);
        run_seq(3, -1, 1, "three");

        clear_runs();
        add_run(10000, 1, 1);
        add_run(2, 3, 1);
        run_seq(2, -1, -1, "start_tmo");

        clear_runs();
        add_run(2, 150, 1);
        add_run(1, 4, 0);
        run_seq(2, -1, -1, "run_tmo");

        clear_runs();
        for (int r = 0; r < 5; r++) add_run(2, 30, 1);
        run_seq(5, 1, 0, "abort");

        clear_runs();
        run_seq(0, -1, -1, "zero");

        clear_runs();
        for (int r = 0; r < 8; r++) begin
            add_run($urandom_range(1, 6), $urandom_range(3, 30),
                    1'($urandom_range(0, 1)));
        end
        run_seq(8, -1, -1, "random");

        clear_runs();
        add_run(2, 3, 1);
        add_run(2, 40, 1);
        add_run(2, 3, 1);
        cur = -1;
        abort_hit = 0;
        start = 1;
        num_runs = CNT_W'(3);
        step();
        start = 0;
        repeat (24) step();
        chk("mid_pre_pass", pass_c, 1);
        chk("mid_pre_do_run", do_run, 1);
        abort_hit = 1;
        reset = 1;
        step();
        reset = 0;
        chk("mid_rst_do_run", do_run, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pass", pass_c, 0);
        chk("mid_rst_last", last_c, 0);
        chk("mid_rst_total", total_c, 0);
        clear_runs();
        cur = -1;
        repeat (3) step();
        chk("post_rst_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/esfa_bench_sequencer.md
Name: esfa_bench_sequencer

Overview:
Hardware benchmark controller for the ESFA top level. It drives the core's doRun/isRunning/wasSuccessful handshake for a programmed number of back-to-back runs and enforces per-phase timeouts. It accumulates pass, fail and timeout counts plus last, max and total cycle statistics. It sits between the bench or host-facing control logic and ESFATop, so the benchmark runs without per-run testbench delays.

Parameters:
CNT_W, 16, width of run-count and result counters
CYC_W, 32, width of cycle counters
START_TIMEOUT, 64, max cycles in WAIT_START for is_running to rise
RUN_TIMEOUT, 1000000, max cycles in WAIT_DONE for is_running to fall
GAP_CYCLES, 4, minimum cycles with do_run low between runs

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high; clears all state and outputs
start  in  1  one-cycle pulse; accepted only in IDLE
abort  in  1  level; stops the sequence at the next edge
num_runs  in  CNT_W  runs to perform; latched on start
do_run  out  1  to ESFATop doRun; registered
dut_is_running  in  1  from ESFATop isRunning
dut_was_successful  in  1  from ESFATop wasSuccessful
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on entering DONE
aborted  out  1  sticky until next accepted start
pass_count  out  CNT_W  runs with was_successful=1
fail_count  out  CNT_W  runs with was_successful=0, excluding timeouts
timeout_count  out  CNT_W  runs that hit either timeout
last_cycles  out  CYC_W  do_run-high cycles of the most recent run
max_cycles  out  CYC_W  maximum last_cycles over the sequence
total_cycles  out  CYC_W  sum of last_cycles over the sequence

Behaviour:
- Reset: state=IDLE. do_run, busy, done and aborted are 0. All counters and cycle outputs are 0.
- IDLE:
  - On start=1, latch num_runs, clear all counters/stats and aborted.
  - If num_runs==0, go to DONE. Otherwise go to LAUNCH.
  - start in any other state is ignored.
- LAUNCH (1 cycle): do_run=1, cyc=1, tmo=0. Next state is WAIT_START.
- WAIT_START: do_run=1, cyc+=1.
  - If dut_is_running=1, go to WAIT_DONE and reset tmo.
  - Else, if tmo==START_TIMEOUT-1, set the timeout flag and go to RECORD.
  - Else tmo+=1.
- WAIT_DONE: do_run=1, cyc+=1.
  - If dut_is_running=0, sample dut_was_successful that cycle and go to RECORD.
  - Else, if tmo==RUN_TIMEOUT-1, set the timeout flag and go to RECORD.
  - Else tmo+=1.
- RECORD (1 cycle):
  - do_run=0. last_cycles=cyc.
  - max_cycles=max(max_cycles, cyc). total_cycles+=cyc, saturating at all-ones.
  - Exactly one of timeout_count, pass_count or fail_count increments, saturating. Timeout takes precedence.
  - remaining-=1. Next state is GAP.
- GAP: do_run=0.
  - Leave when at least GAP_CYCLES cycles have elapsed in GAP AND dut_is_running=0. A timed-out core must drop is_running before the next run.
  - Then go to LAUNCH if remaining>0, else DONE.
- DONE (1 cycle): done=1, next state is IDLE. Results hold until the next accepted start.
- The cyc counter saturates at all-ones and never wraps.
- abort=1 in LAUNCH, WAIT_START, WAIT_DONE or GAP:
  - Next cycle, do_run=0 and aborted=1; go to GAP with remaining forced to 0.
  - An in-flight run is not recorded in any counter.
  - abort in IDLE or DONE has no effect.
- abort has priority over a completion or timeout on the same edge.
- reset mid-sequence: synchronous return to IDLE; do_run drops on that edge.
- Counter invariant at DONE without abort: pass+fail+timeout == latched num_runs.

Test Plan:
- Core model raises is_running 2 cycles after do_run rises and holds it 8 cycles, success=1; num_runs=1 -> do_run high 11 cycles, last_cycles=11, pass_count=1, done pulses once, busy falls the cycle after done.
- num_runs=3, successes 1,0,1, run lengths 8/20/5 -> pass=2, fail=1, max_cycles=23, total_cycles=11+23+8=42, do_run low ≥4 cycles between runs.
- Core never raises is_running, START_TIMEOUT=64 -> timeout_count=1, last_cycles=65, do_run drops, sequence continues to the next run.
- is_running stuck high past RUN_TIMEOUT (set to 100) -> timeout_count=1. GAP holds until is_running falls; next LAUNCH occurs only after that.
- abort asserted mid-WAIT_DONE of run 2 of 5 -> do_run low next cycle, aborted=1, pass_count=1, done pulses after GAP; start pulses while busy are ignored.
- num_runs=0 -> done the cycle after start, all counters 0, do_run never rises; reset asserted mid-run -> all outputs 0 next cycle.
